// File: rtl/pll_lock_if.sv
// PLL supervision bus: lock/request inputs toward the sequencer, reset/status outputs from it.
interface pll_lock_if;
  logic       locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst_out;
  logic       ready;
  logic       fault;
  logic [2:0] retry_count;
  logic [2:0] state;

  modport master (
    input  locked, relock_req,
    output pll_rst, sys_rst_out, ready, fault, retry_count, state
  );

  modport slave (
    output locked, relock_req,
    input  pll_rst, sys_rst_out, ready, fault, retry_count, state
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Pixel-PLL reset/lock supervisor on refclk; holds sys_rst_out until lock is stable, retries, then faults.
// Latency: locked -> state reaction in 3 refclk cycles (2-flop sync + registered state); LOCK_LOSS_FILTER_EN debounces loss in RUN.
// No backpressure: relock_req is a single-cycle pulse, acted on only in RUN and FAULT.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 20,
  parameter int LOSS_FILTER   = 8
) (
  input  logic          refclk,
  input  logic          rst,
  pll_lock_if.master    bus
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       MAX_R    = 3'(MAX_RETRIES);

  if (MAX_RETRIES > 7 || LOSS_FILTER < 1) begin : g_bad_param
    $error("pll_lock_sequencer: MAX_RETRIES must fit 3 bits and LOSS_FILTER must be >= 1");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         retry_q, retry_d;
  logic [1:0]         lock_sync;
  logic               locked_s;
  logic               lock_loss;

  // locked comes from the PLL output domain; two flops before any decision uses it.
  always_ff @(posedge refclk) begin
    if (rst) lock_sync <= 2'b00;
    else     lock_sync <= {lock_sync[0], bus.locked};
  end
  assign locked_s = lock_sync[1];

`ifdef LOCK_LOSS_FILTER_EN
  localparam int               FLT_W    = $clog2(LOSS_FILTER + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOSS_FILTER - 1);
  logic [FLT_W-1:0] flt_q;

  // Counts consecutive low samples while in RUN; held at zero elsewhere so RUN entry starts clean.
  always_ff @(posedge refclk) begin
    if (rst || state_q != ST_RUN || locked_s) flt_q <= '0;
    else if (flt_q != FLT_LAST)               flt_q <= flt_q + FLT_W'(1);
  end
  assign lock_loss = !locked_s && (flt_q == FLT_LAST);
`else
  assign lock_loss = !locked_s;
`endif

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d = '0;
          if (retry_q == MAX_R) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + 3'd1;
            state_d = ST_PLL_RST;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // A dropout restarts the stability window but does not consume a retry.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (lock_loss || bus.relock_req) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_FAULT: begin
        if (bus.relock_req) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
        retry_d = '0;
      end
    endcase
  end

  assign bus.state       = state_q;
  assign bus.retry_count = retry_q;
  assign bus.pll_rst     = (state_q == ST_PLL_RST) || (state_q == ST_FAULT);
  assign bus.sys_rst_out = (state_q != ST_RUN);
  assign bus.ready       = (state_q == ST_RUN);
  assign bus.fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed lock/retry/fault scenarios with literal timings, then random locked/relock/rst traffic against a phase model.
module tb_pll_lock_sequencer;
  localparam int RST_C = 4;
  localparam int TMO   = 20;
  localparam int STB   = 8;
  localparam int MAXR  = 2;
  localparam int LOSSF = 8;
`ifdef LOCK_LOSS_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int LOSS_LAT = FILT ? (3 + LOSSF - 1) : 3;

  localparam int PH_RST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAULT = 4;

  logic refclk = 1'b0;
  logic rst;
  always #5 refclk = ~refclk;

  pll_lock_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STB),
    .MAX_RETRIES(MAXR), .CNT_W(20), .LOSS_FILTER(LOSSF)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: which phase we are in, how many cycles spent there, and the lock history.
  typedef struct {
    int ph;
    int elapsed;
    int retries;
    bit h0;
    bit h1;
    int lowrun;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, logic r, logic lk, logic rq);
    model_t n;
    bit     ls;
    bit     loss;
    n    = c;
    ls   = c.h1;
    n.h1 = c.h0;
    n.h0 = lk;
    n.lowrun = 0;
    if (r) begin
      n.ph = PH_RST; n.elapsed = 0; n.retries = 0; n.h0 = 0; n.h1 = 0;
      return n;
    end
    case (c.ph)
      PH_RST: begin
        if (c.elapsed + 1 == RST_C) begin n.ph = PH_WAIT; n.elapsed = 0; end
        else n.elapsed = c.elapsed + 1;
      end
      PH_WAIT: begin
        if (ls) begin n.ph = PH_STABLE; n.elapsed = 0; end
        else if (c.elapsed + 1 == TMO) begin
          n.elapsed = 0;
          if (c.retries == MAXR) n.ph = PH_FAULT;
          else begin n.ph = PH_RST; n.retries = c.retries + 1; end
        end else n.elapsed = c.elapsed + 1;
      end
      PH_STABLE: begin
        if (!ls) begin n.ph = PH_WAIT; n.elapsed = 0; end
        else if (c.elapsed + 1 == STB) begin n.ph = PH_RUN; n.elapsed = 0; end
        else n.elapsed = c.elapsed + 1;
      end
      PH_RUN: begin
        n.lowrun = ls ? 0 : c.lowrun + 1;
        loss = FILT ? (n.lowrun >= LOSSF) : !ls;
        if (loss || rq) begin n.ph = PH_RST; n.elapsed = 0; n.retries = 0; n.lowrun = 0; end
      end
      default: begin
        if (rq) begin n.ph = PH_RST; n.elapsed = 0; n.retries = 0; end
      end
    endcase
    return n;
  endfunction

  function automatic logic [9:0] expect_vec(model_t c);
    logic [2:0] ph3;
    logic [2:0] rt3;
    ph3 = 3'(c.ph);
    rt3 = 3'(c.retries);
    return {(c.ph == PH_RST || c.ph == PH_FAULT), (c.ph != PH_RUN),
            (c.ph == PH_RUN), (c.ph == PH_FAULT), rt3, ph3};
  endfunction

  always @(posedge refclk) m <= step(m, rst, bus.locked, bus.relock_req);

  always @(negedge refclk) begin
    if (chk_en)
      chk("cycle_outputs",
          {22'd0, bus.pll_rst, bus.sys_rst_out, bus.ready, bus.fault, bus.retry_count, bus.state},
          {22'd0, expect_vec(m)});
  end

  function automatic int sig(int sel);
    case (sel)
      0: return int'(bus.pll_rst);
      1: return int'(bus.ready);
      2: return int'(bus.state);
      default: return int'(bus.fault);
    endcase
  endfunction

  task automatic count_until(input int sel, input int val, output int n);
    n = 0;
    while (n < 300 && sig(sel) != val) begin
      @(negedge refclk);
      n++;
    end
  endtask

  int n;
  int n_hold;

  initial begin
    rst = 1'b1;
    bus.locked = 1'b0;
    bus.relock_req = 1'b0;
    repeat (3) @(negedge refclk);
    chk_en = 1'b1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_pll_rst", 32'(bus.pll_rst), 1);
    chk("rst_sys_rst", 32'(bus.sys_rst_out), 1);
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_retry", 32'(bus.retry_count), 0);

    rst = 1'b0;
    count_until(0, 0, n);            chk("first_pll_rst_len", n, 4);
    repeat (6) @(negedge refclk);
    bus.locked = 1'b1;
    count_until(2, 2, n);            chk("lock_to_stable", n, 3);
    count_until(1, 1, n);            chk("stable_to_ready", n, 8);
    chk("run_sys_rst", 32'(bus.sys_rst_out), 0);
    chk("run_retry", 32'(bus.retry_count), 0);

    // Software relock from RUN, then a one-cycle dropout during STABLE.
    bus.relock_req = 1'b1; @(negedge refclk); bus.relock_req = 1'b0;
    chk("relock_in_run", 32'(bus.state), 0);
    count_until(2, 2, n);            chk("relock_to_stable", n, 5);
    repeat (3) @(negedge refclk);
    bus.locked = 1'b0; @(negedge refclk); bus.locked = 1'b1;
    count_until(2, 1, n);            chk("dropout_to_wait", n, 2);
    count_until(2, 2, n);            chk("wait_to_stable", n, 1);
    count_until(1, 1, n);            chk("restable_to_ready", n, 8);
    chk("dropout_retry", 32'(bus.retry_count), 0);

    // Lock loss in RUN.
    bus.locked = 1'b0;
    count_until(1, 0, n);            chk("loss_to_not_ready", n, LOSS_LAT);
    chk("loss_state", 32'(bus.state), 0);
    count_until(0, 0, n);            chk("loss_pll_rst_len", n, 4);
    chk("loss_retry", 32'(bus.retry_count), 0);

    // relock_req in WAIT_LOCK is ignored; then run out of retries.
    repeat (2) @(negedge refclk);
    bus.relock_req = 1'b1; @(negedge refclk); bus.relock_req = 1'b0;
    chk("relock_ignored_wait", 32'(bus.state), 1);
    count_until(3, 1, n);            chk("time_to_fault", n, 65);
    chk("fault_retry", 32'(bus.retry_count), 2);
    chk("fault_pll_rst", 32'(bus.pll_rst), 1);
    chk("fault_sys_rst", 32'(bus.sys_rst_out), 1);
    chk("fault_state", 32'(bus.state), 4);
    n_hold = 0;
    repeat (100) begin
      @(negedge refclk);
      if (bus.fault && bus.state == 3'd4 && bus.pll_rst) n_hold++;
    end
    chk("fault_hold_100", n_hold, 100);

    bus.locked = 1'b1;
    repeat (3) @(negedge refclk);
    bus.relock_req = 1'b1; @(negedge refclk); bus.relock_req = 1'b0;
    chk("fault_exit_fault", 32'(bus.fault), 0);
    chk("fault_exit_state", 32'(bus.state), 0);
    chk("fault_exit_retry", 32'(bus.retry_count), 0);
    count_until(1, 1, n);            chk("fault_exit_to_ready", n, 13);

    // Three-cycle glitch in RUN.
    bus.locked = 1'b0;
    repeat (3) @(negedge refclk);
    chk("glitch_state", 32'(bus.state), FILT ? 3 : 0);
    bus.locked = 1'b1;
    count_until(1, 1, n);            chk("glitch_to_ready", n, FILT ? 0 : 13);

    // Random traffic against the model.
    for (int s = 0; s < 150; s++) begin
      automatic logic lvl = ($urandom_range(0, 3) != 0);
      automatic int   len = ($urandom_range(0, 7) == 0) ? $urandom_range(50, 150) : $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        @(negedge refclk);
        bus.locked     = lvl;
        bus.relock_req = ($urandom_range(0, 59) == 0);
        rst            = ($urandom_range(0, 799) == 0);
      end
    end
    @(negedge refclk);
    rst = 1'b0;
    bus.relock_req = 1'b0;
    repeat (5) @(negedge refclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
